// File: rtl/shift_pkg.sv
// Shared types and defaults for the serial shifter link (transmitter and receiver).
package shift_pkg;

    typedef enum logic {IDLE, SHIFT} rx_state_t;

    localparam int SHIFT_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/shift_s_to_p_rx_if.sv
// Serial-in / parallel-out bus of the receiver; master drives the link and consumer side.
interface shift_s_to_p_rx_if
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH_DEFAULT
);
    logic             sIn;
    logic             bitEn;
    logic             start;
    logic             dataReady;
    logic             clrErr;
    logic [WIDTH-1:0] data;
    logic             dataValid;
    logic             busy;
    logic             overrun;
    logic             frameErr;

    modport master (
        output sIn, bitEn, start, dataReady, clrErr,
        input  data, dataValid, busy, overrun, frameErr
    );

    modport slave (
        input  sIn, bitEn, start, dataReady, clrErr,
        output data, dataValid, busy, overrun, frameErr
    );

endinterface

// File: rtl/shift_s_to_p_rx.sv
// Serial-to-parallel receiver: MSB-first framed bitstream into a double-buffered word
// with valid/ready handshake and sticky overrun / framing-error flags.
module shift_s_to_p_rx
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH_DEFAULT
) (
    input  logic              Clock,
    input  logic              rst,
    shift_s_to_p_rx_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);

    rx_state_t        state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             done, ferr_set, ovr_set;

    logic [WIDTH-1:0] data_q;
    logic             valid_q, ovr_q, ferr_q;

    always_ff @(posedge Clock) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            shreg <= shreg_n;
        end
    end

    // On completion shreg_n already holds the finished word, so it feeds the output buffer directly.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shreg_n  = shreg;
        done     = 1'b0;
        ferr_set = 1'b0;
        if (bus.bitEn) begin
            if (state == IDLE) begin
                if (bus.start) begin
                    state_n = SHIFT;
                    cnt_n   = CW'(1);
                    shreg_n = WIDTH'(bus.sIn);
                end
            end else if (bus.start) begin
                ferr_set = 1'b1;
                cnt_n    = CW'(1);
                shreg_n  = WIDTH'(bus.sIn);
            end else begin
                shreg_n = {shreg[WIDTH-2:0], bus.sIn};
                if (cnt == CW'(WIDTH - 1)) begin
                    done    = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
        end
    end

    assign ovr_set = done && valid_q && !bus.dataReady;

    always_ff @(posedge Clock) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            if (done && (!valid_q || bus.dataReady)) begin
                data_q  <= shreg_n;
                valid_q <= 1'b1;
            end else if (!done && valid_q && bus.dataReady) begin
                valid_q <= 1'b0;
            end
            // A new error event on the same edge as clrErr leaves the flag set.
            ovr_q  <= (ovr_q  && !bus.clrErr) || ovr_set;
            ferr_q <= (ferr_q && !bus.clrErr) || ferr_set;
        end
    end

    always_comb begin
        bus.data      = data_q;
        bus.dataValid = valid_q;
        bus.busy      = (state == SHIFT);
        bus.overrun   = ovr_q;
        bus.frameErr  = ferr_q;
    end

endmodule

// File: tb/tb_shift_s_to_p_rx.sv
// Bench for shift_s_to_p_rx: bit-queue reference model feeding a word scoreboard, directed cases then random traffic.
module tb_shift_s_to_p_rx;

    localparam int W = 8;

    logic Clock = 1'b0;
    logic rst;
    always #5 Clock = ~Clock;

    shift_s_to_p_rx_if #(.WIDTH(W)) ifc ();
    shift_s_to_p_rx #(.WIDTH(W)) dut (.Clock(Clock), .rst(rst), .bus(ifc));

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] sb[$];
    int           bits[$];
    bit           m_valid, m_ovr, m_ferr, started;
    bit           prev_valid, prev_ready;
    int           busy_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect framed bits in a queue, build the word arithmetically on the last bit.
    bit           m_done, m_fe, m_ov;
    logic [W-1:0] m_word;
    always @(posedge Clock) begin
        started = 1'b1;
        m_done  = 1'b0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
        m_word  = '0;
        if (rst) begin
            bits.delete();
            sb.delete();
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_ferr  = 1'b0;
        end else begin
            if (ifc.bitEn) begin
                if (ifc.start) begin
                    if (bits.size() > 0) m_fe = 1'b1;
                    bits.delete();
                    bits.push_back(int'(ifc.sIn));
                end else if (bits.size() > 0) begin
                    bits.push_back(int'(ifc.sIn));
                    if (bits.size() == W) begin
                        m_done = 1'b1;
                        foreach (bits[i]) m_word = W'(m_word * 2 + bits[i]);
                        bits.delete();
                    end
                end
            end
            if (m_done) begin
                if (!m_valid || ifc.dataReady) begin
                    sb.push_back(m_word);
                    m_valid = 1'b1;
                end else begin
                    m_ov = 1'b1;
                end
            end else if (m_valid && ifc.dataReady) begin
                m_valid = 1'b0;
            end
            m_ovr  = (m_ovr  && !ifc.clrErr) || m_ov;
            m_ferr = (m_ferr && !ifc.clrErr) || m_fe;
        end
    end

    // Monitor: a fresh word is on the output when valid follows an idle or consumed cycle.
    always @(negedge Clock) begin
        if (started) begin
            busy_cnt += int'(ifc.busy);
            check("busy",      32'(ifc.busy),      32'(bits.size() > 0));
            check("dataValid", 32'(ifc.dataValid), 32'(m_valid));
            check("overrun",   32'(ifc.overrun),   32'(m_ovr));
            check("frameErr",  32'(ifc.frameErr),  32'(m_ferr));
            if (ifc.dataValid === 1'b1 && (!prev_valid || prev_ready)) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL data unexpected word actual=%0h expected=none", ifc.data);
                end else begin
                    check("data", 32'(ifc.data), 32'(sb.pop_front()));
                end
            end
            prev_valid = (ifc.dataValid === 1'b1);
            prev_ready = ifc.dataReady;
        end
    end

    task automatic cyc(input logic be, input logic st, input logic s);
        ifc.bitEn = be;
        ifc.start = st;
        ifc.sIn   = s;
        @(posedge Clock);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w, input int gap);
        for (int i = W - 1; i >= 0; i--) begin
            cyc(1'b1, i == W - 1, w[i]);
            if (i > 0) repeat (gap) cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [W-1:0] w;
        int n, lat;
        rst = 1'b1;
        ifc.bitEn = 0; ifc.start = 0; ifc.sIn = 0; ifc.dataReady = 0; ifc.clrErr = 0;
        repeat (2) @(posedge Clock);
        #1;
        check("rst data",     32'(ifc.data),      32'h0);
        check("rst valid",    32'(ifc.dataValid), 32'h0);
        check("rst busy",     32'(ifc.busy),      32'h0);
        check("rst overrun",  32'(ifc.overrun),   32'h0);
        check("rst frameErr", 32'(ifc.frameErr),  32'h0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, logic'(i % 2));
        check("no start busy", 32'(ifc.busy), 32'h0);

        ifc.dataReady = 1'b1;
        busy_cnt = 0;
        send(8'h85, 0);
        check("t2 valid", 32'(ifc.dataValid), 32'h1);
        check("t2 data",  32'(ifc.data),      32'h85);
        cyc(1'b0, 1'b0, 1'b0);
        check("t2 busy cycles", 32'(busy_cnt), 32'd7);
        check("t2 valid drop",  32'(ifc.dataValid), 32'h0);

        w = 8'hAA; n = 0; lat = 0;
        for (int i = W - 1; i >= 0; i--) begin
            cyc(1'b1, i == W - 1, w[i]);
            n++;
            if (ifc.dataValid && lat == 0) lat = n;
            if (i > 0) begin
                cyc(1'b0, 1'b0, 1'b0);
                n++;
                if (ifc.dataValid && lat == 0) lat = n;
            end
        end
        check("t3 latency", 32'(lat), 32'd15);
        check("t3 data", 32'(ifc.data), 32'hAA);
        cyc(1'b0, 1'b0, 1'b0);

        ifc.dataReady = 1'b0;
        send(8'hD2, 0);
        send(8'h11, 0);
        check("t4 data",    32'(ifc.data),      32'hD2);
        check("t4 valid",   32'(ifc.dataValid), 32'h1);
        check("t4 overrun", 32'(ifc.overrun),   32'h1);
        ifc.clrErr = 1'b1; ifc.dataReady = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        ifc.clrErr = 1'b0;
        check("t4 clr overrun", 32'(ifc.overrun),   32'h0);
        check("t4 clr valid",   32'(ifc.dataValid), 32'h0);

        cyc(1'b1, 1'b1, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 1'b1);
        ifc.clrErr = 1'b1;
        w = 8'h5A;
        cyc(1'b1, 1'b1, w[7]);
        ifc.clrErr = 1'b0;
        for (int i = W - 2; i >= 0; i--) cyc(1'b1, 1'b0, w[i]);
        check("t5 frameErr", 32'(ifc.frameErr), 32'h1);
        check("t5 data",     32'(ifc.data),     32'h5A);
        ifc.clrErr = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        ifc.clrErr = 1'b0;

        cyc(1'b1, 1'b1, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        check("t6 rst busy",  32'(ifc.busy),      32'h0);
        check("t6 rst valid", 32'(ifc.dataValid), 32'h0);
        repeat (4) cyc(1'b1, 1'b0, 1'b1);
        check("t6 orphan bits", 32'(ifc.dataValid), 32'h0);
        ifc.dataReady = 1'b0;
        send(8'h3C, 0);
        check("t6 data", 32'(ifc.data), 32'h3C);
        w = 8'h96;
        for (int i = W - 1; i > 0; i--) cyc(1'b1, i == W - 1, w[i]);
        ifc.dataReady = 1'b1;
        cyc(1'b1, 1'b0, w[0]);
        check("t6 coincide data",    32'(ifc.data),      32'h96);
        check("t6 coincide valid",   32'(ifc.dataValid), 32'h1);
        check("t6 coincide overrun", 32'(ifc.overrun),   32'h0);

        for (int i = 0; i < 1500; i++) begin
            rst           = ($urandom_range(0, 199) == 0);
            ifc.dataReady = logic'($urandom_range(0, 1));
            ifc.clrErr    = ($urandom_range(0, 19) == 0);
            cyc(logic'($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0), logic'($urandom_range(0, 1)));
        end
        rst = 1'b0; ifc.clrErr = 1'b0; ifc.dataReady = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
